decode_ctrl: RTL and testbench
==============================

# decode_ctrl

Multicycle fetch/decode/control FSM for the 8-bit CPU. It sits directly upstream of `regfile` and drives that block's `ra1`/`ra2`/`wa3`/`we3`. It also drives the program counter, the ALU/memory control and the write-back data select. Each instruction is fetched through a valid-handshaked instruction port and sequenced through decode, execute, optional memory access and write-back.

## Interface
- `DWIDTH`, 8, datapath width; sets the sign-extended immediate width.
- `RWIDTH`, 3, register address width.
- `PWIDTH`, 8, PC width.
- `IWIDTH`, 16, instruction width; fixed at 16 by the encoding below.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc` out PWIDTH: fetch address.
- `imem_req` out 1: fetch request.
- `imem_valid` in 1: `instr` is valid this cycle.
- `instr` in IWIDTH: fetched instruction.
- `ra1`, `ra2` out RWIDTH: register read addresses.
- `wa3` out RWIDTH: register write address.
- `we3` out 1: register write enable.
- `alu_ctrl` out 3: ALU function. ADD=0, SUB=1, AND=2, OR=3.
- `alu_src` out 1: 1 selects `imm` as ALU operand B.
- `imm` out DWIDTH: sign-extended imm6.
- `alu_zero` in 1: ALU result is zero.
- `mem_req` out 1: data-memory access request.
- `mem_we` out 1: data-memory write qualifier.
- `mem_ready` in 1: data access complete.
- `wd_sel` out 1: write-back data select; 0 selects ALU, 1 selects memory.
- `halted` out 1: core stopped.
- `illegal` out 1: sticky; an undefined opcode was executed.

## Operation
Encoding:
- [15:12] opcode.
- [11:9] rd.
- [8:6] rs1.
- [5:3] rs2.
- [5:0] imm6.
- [7:0] jump target.

Opcodes:
- 0 NOP.
- 1 ADD, 2 SUB, 3 AND, 4 OR: rd = rs1 op rs2.
- 5 ADDI: rd = rs1 + imm.
- 6 LD: rd = M[rs1 + imm].
- 7 ST: M[rs1 + imm] = rs2. Here `ra2` = IR[11:9]; the rd field is the store source.
- 8 BEQ: if rs1 == rs2, branch to pc+1+imm.
- 9 J: jump to IR[7:0].
- 15 HALT.
- 10–14: illegal; set `illegal` and execute as NOP.

States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `imem_req`=1. On `imem_valid`, IR <= `instr` and go to DECODE; otherwise stay.
- DECODE: always go to EXEC.
  - `ra1`, `ra2` and `imm` are combinational from IR in every state.
  - For BEQ, `alu_ctrl` is SUB.
- EXEC: drive `alu_ctrl` and `alu_src`, then branch on opcode:
  - R-type/ADDI: go to WB.
  - LD/ST: go to MEM.
  - BEQ: pc <= `alu_zero` ? pc+1+imm : pc+1; go to FETCH.
  - J: pc <= IR[7:0]; go to FETCH.
  - NOP/illegal: pc <= pc+1; go to FETCH.
  - HALT: go to HALT; pc is unchanged.
- MEM: `mem_req`=1, `mem_we`=(op==ST), ALU controls held. Stay until `mem_ready`, then:
  - ST: pc <= pc+1; go to FETCH.
  - LD: go to WB.
- WB: `we3`=1 for exactly one cycle, `wa3`=rd, `wd_sel`=(op==LD), ALU controls held; pc <= pc+1; go to FETCH.
  - rd=0 still asserts `we3`; the regfile discards it.
- HALT: `halted`=1; remain here until reset; all request and write outputs are 0.

Width and arithmetic rules:
- PC arithmetic is modulo 2^PWIDTH; 0xFF+1 wraps to 0x00.
- The branch offset imm6 is sign-extended to PWIDTH.
- `imm` is sign-extended to DWIDTH.

## Timing
- Reset (asynchronous):
  - state=FETCH, pc=0, IR=0, `illegal`=0.
  - `imem_req`=1, since FETCH is entered on reset.
  - All other outputs 0.
- The first fetch request is in the cycle after reset deasserts.
- All control outputs are Moore: decoded from state and IR only, with no combinational path from `imem_valid`/`mem_ready`.
- Latency with zero-wait memories (`imem_valid`/`mem_ready` high on the first request cycle):
  - R/ADDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ/J/NOP: 3 cycles.
  - Each wait cycle adds one.
- The `we3` pulse aligns with the regfile write edge at the end of WB.
- Reset asserted mid-instruction aborts it with no `we3` and no `mem_req` after the reset edge.
- `instr` is ignored outside FETCH.
- `alu_zero` is sampled only in EXEC of BEQ.

## Structure
- Package `cpu_pkg`:
  - Opcode enum.
  - State enum.
  - ALU function constants.
  - Field-position localparams.
- Sub-module `instr_decode`: combinational IR -> {rs1, rs2, rd, imm, opcode class, `alu_ctrl`, illegal}.
- The FSM and PC register stay in `decode_ctrl`.

## Test plan
- ADD: reset, then `instr`=0x1298 (ADD r1,r2,r3) with `imem_valid` high. Required: `ra1`=2, `ra2`=3, `alu_ctrl`=0; `we3`=1 with `wa3`=1 in cycle 4; pc becomes 1.
- LD with wait: `instr`=0x6285 (LD r1,[r2+5]) with `mem_ready` delayed 3 cycles. Required:
  - `mem_req` high for 4 cycles, `mem_we`=0, `imm`=0x05.
  - One `we3` with `wd_sel`=1.
  - 8 total cycles.
- BEQ taken: pc=0x10, `instr`=0x80BE (imm=-2), `alu_zero`=1. Required: pc becomes 0x0F and `we3` never asserts.
- BEQ not taken: same instruction with `alu_zero`=0. Required: pc becomes 0x11.
- PC wrap and jump:
  - J with target 0xFF, then NOP. Required: pc goes 0xFF then 0x00.
  - Opcode 0xA. Required: `illegal` goes high and stays high.
- HALT and mid-operation reset:
  - HALT. Required: `halted`=1 and `imem_req` stays 0 for 20 cycles.
  - Reset asserted during MEM of a ST. Required: immediate `mem_req`=0 and pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU fetch/decode/control path.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_J    = 4'd9,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  // Sequencing class: R-type and ADDI share the EXEC->WB path.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_BEQ,
    CLS_J,
    CLS_HALT
  } iclass_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_W   = 6;
  localparam int TGT_W   = 8;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction-register decode: register fields, immediate,
// sequencing class, ALU function and illegal-opcode flag.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 3,
  parameter int IWIDTH = 16
) (
  input  logic [IWIDTH-1:0] ir_i,
  output logic [RWIDTH-1:0] rs1_o,
  output logic [RWIDTH-1:0] rs2_o,
  output logic [RWIDTH-1:0] rd_o,
  output logic [DWIDTH-1:0] imm_o,
  output iclass_e           cls_o,
  output logic [2:0]        alu_ctrl_o,
  output logic              alu_src_o,
  output logic              illegal_o
);

  logic [3:0] op;

  assign op    = ir_i[OP_MSB:OP_LSB];
  assign rs1_o = ir_i[RS1_LSB +: RWIDTH];
  assign rd_o  = ir_i[RD_LSB +: RWIDTH];
  // A store reads its data register through the rd field.
  assign rs2_o = (op == OP_ST) ? ir_i[RD_LSB +: RWIDTH] : ir_i[RS2_LSB +: RWIDTH];
  assign imm_o = {{(DWIDTH-IMM_W){ir_i[IMM_W-1]}}, ir_i[IMM_W-1:0]};

  always_comb begin
    cls_o      = CLS_NOP;
    alu_ctrl_o = ALU_ADD;
    alu_src_o  = 1'b0;
    illegal_o  = 1'b0;
    case (op)
      OP_NOP:  cls_o = CLS_NOP;
      OP_ADD:  cls_o = CLS_ALU;
      OP_SUB:  begin cls_o = CLS_ALU; alu_ctrl_o = ALU_SUB; end
      OP_AND:  begin cls_o = CLS_ALU; alu_ctrl_o = ALU_AND; end
      OP_OR:   begin cls_o = CLS_ALU; alu_ctrl_o = ALU_OR;  end
      OP_ADDI: begin cls_o = CLS_ALU; alu_src_o  = 1'b1;    end
      OP_LD:   begin cls_o = CLS_LD;  alu_src_o  = 1'b1;    end
      OP_ST:   begin cls_o = CLS_ST;  alu_src_o  = 1'b1;    end
      OP_BEQ:  begin cls_o = CLS_BEQ; alu_ctrl_o = ALU_SUB; end
      OP_J:    cls_o = CLS_J;
      OP_HALT: cls_o = CLS_HALT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Multicycle fetch/decode/execute/memory/write-back sequencer with PC and IR.
// All control outputs are Moore, decoded from the state and IR registers.
module decode_ctrl
  import cpu_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 3,
  parameter int PWIDTH = 8,
  parameter int IWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PWIDTH-1:0] pc,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [IWIDTH-1:0] instr,
  output logic [RWIDTH-1:0] ra1,
  output logic [RWIDTH-1:0] ra2,
  output logic [RWIDTH-1:0] wa3,
  output logic              we3,
  output logic [2:0]        alu_ctrl,
  output logic              alu_src,
  output logic [DWIDTH-1:0] imm,
  input  logic              alu_zero,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              wd_sel,
  output logic              halted,
  output logic              illegal
);

  state_e            state_q;
  logic [PWIDTH-1:0] pc_q;
  logic [IWIDTH-1:0] ir_q;
  logic              illegal_q;

  logic [RWIDTH-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [DWIDTH-1:0] dec_imm;
  iclass_e           dec_cls;
  logic [2:0]        dec_alu_ctrl;
  logic              dec_alu_src;
  logic              dec_illegal;

  instr_decode #(
    .DWIDTH(DWIDTH),
    .RWIDTH(RWIDTH),
    .IWIDTH(IWIDTH)
  ) u_dec (
    .ir_i      (ir_q),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .rd_o      (dec_rd),
    .imm_o     (dec_imm),
    .cls_o     (dec_cls),
    .alu_ctrl_o(dec_alu_ctrl),
    .alu_src_o (dec_alu_src),
    .illegal_o (dec_illegal)
  );

  logic [PWIDTH-1:0] pc_inc, pc_off, pc_br, pc_tgt;

  // Branch offset is extended to the PC width, independent of DWIDTH.
  assign pc_off = {{(PWIDTH-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign pc_inc = pc_q + PWIDTH'(1);
  assign pc_br  = pc_inc + pc_off;
  assign pc_tgt = PWIDTH'(ir_q[TGT_W-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_valid) begin
            ir_q    <= instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: state_q <= ST_EXEC;
        ST_EXEC: begin
          if (dec_illegal) illegal_q <= 1'b1;
          case (dec_cls)
            CLS_ALU:        state_q <= ST_WB;
            CLS_LD, CLS_ST: state_q <= ST_MEM;
            CLS_BEQ: begin
              pc_q    <= alu_zero ? pc_br : pc_inc;
              state_q <= ST_FETCH;
            end
            CLS_J: begin
              pc_q    <= pc_tgt;
              state_q <= ST_FETCH;
            end
            CLS_HALT:       state_q <= ST_HALT;
            default: begin
              pc_q    <= pc_inc;
              state_q <= ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (dec_cls == CLS_ST) begin
              pc_q    <= pc_inc;
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_WB;
            end
          end
        end
        ST_WB: begin
          pc_q    <= pc_inc;
          state_q <= ST_FETCH;
        end
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end

  logic alu_active;

  assign alu_active = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                      (state_q == ST_MEM)    || (state_q == ST_WB);

  assign pc       = pc_q;
  assign imem_req = (state_q == ST_FETCH);
  assign ra1      = dec_rs1;
  assign ra2      = dec_rs2;
  assign imm      = dec_imm;
  assign alu_ctrl = alu_active ? dec_alu_ctrl : ALU_ADD;
  assign alu_src  = alu_active & dec_alu_src;
  assign mem_req  = (state_q == ST_MEM);
  assign mem_we   = (state_q == ST_MEM) && (dec_cls == CLS_ST);
  assign we3      = (state_q == ST_WB);
  assign wa3      = (state_q == ST_WB) ? dec_rd : '0;
  assign wd_sel   = (state_q == ST_WB) && (dec_cls == CLS_LD);
  assign halted   = (state_q == ST_HALT);
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed-vector bench for decode_ctrl with hand-computed expectations.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pc;
  logic        imem_req;
  logic        imem_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [2:0]  ra1, ra2, wa3;
  logic        we3;
  logic [2:0]  alu_ctrl;
  logic        alu_src;
  logic [7:0]  imm;
  logic        alu_zero = 1'b0;
  logic        mem_req, mem_we;
  logic        mem_ready = 1'b0;
  logic        wd_sel, halted, illegal;

  int total = 0;
  int bad = 0;

  int   r_cyc, r_mem, r_we;
  logic r_wdsel, r_memwe, r_src;
  logic [2:0] r_ctl, r_wa3;

  decode_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_req(imem_req),
    .imem_valid(imem_valid), .instr(instr), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .we3(we3), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .imm(imm), .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ready(mem_ready), .wd_sel(wd_sel), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until the core is back in FETCH or halted.
  // Outside FETCH an illegal opcode is driven on instr to expose stray latching.
  task automatic run_instr(input logic [15:0] ins, input int vwait, input int rwait,
                           input logic zero);
    int fw, mw;
    logic fetched, done, fire;
    r_cyc = 0; r_mem = 0; r_we = 0; r_wdsel = 0; r_memwe = 0;
    r_src = 0; r_ctl = 0; r_wa3 = 0;
    fw = 0; mw = 0; fetched = 0; done = 0;
    alu_zero = zero;
    while (!done && r_cyc < 60) begin
      r_cyc++;
      imem_valid = 1'b0;
      mem_ready  = 1'b0;
      instr      = imem_req ? ins : 16'hA000;
      if (imem_req) begin
        fire = (fw >= vwait);
        imem_valid = fire;
        if (fire) fetched = 1'b1;
        fw++;
      end
      if (mem_req) begin
        r_mem++;
        if (mem_we) r_memwe = 1'b1;
        mem_ready = (mw >= rwait);
        mw++;
      end
      if (we3) begin
        r_we++;
        r_wdsel = wd_sel;
        r_wa3 = wa3;
      end
      if (r_cyc == vwait + 3) begin
        r_ctl = alu_ctrl;
        r_src = alu_src;
      end
      tick();
      if (fetched && (imem_req || halted)) done = 1'b1;
    end
    imem_valid = 1'b0;
    mem_ready  = 1'b0;
    if (!done) chk("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_imem_req", imem_req, 1'b1);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_outs", {we3, mem_req, mem_we, wd_sel, halted, alu_src, alu_ctrl, wa3}, 32'd0);
    chk("rst_ir_fields", {ra1, ra2, imm}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int hreq;
    #2;
    do_reset();

    // ADD r1,r2,r3
    run_instr(16'h1298, 0, 0, 1'b0);
    chk("add_cyc", r_cyc, 4);
    chk("add_we_cnt", r_we, 1);
    chk("add_wa3", r_wa3, 3'd1);
    chk("add_ctl", r_ctl, 3'd0);
    chk("add_src", r_src, 1'b0);
    chk("add_wdsel", r_wdsel, 1'b0);
    chk("add_ra", {ra1, ra2}, {3'd2, 3'd3});
    chk("add_pc", pc, 8'h01);

    // SUB r4,r1,r2 with two fetch wait cycles
    run_instr(16'h2850, 2, 0, 1'b0);
    chk("sub_cyc", r_cyc, 6);
    chk("sub_ctl", r_ctl, 3'd1);
    chk("sub_wa3", r_wa3, 3'd4);
    chk("sub_pc", pc, 8'h02);

    // ADDI r3,r1,-1
    run_instr(16'h567F, 0, 0, 1'b0);
    chk("addi_cyc", r_cyc, 4);
    chk("addi_src", r_src, 1'b1);
    chk("addi_imm", imm, 8'hFF);
    chk("addi_pc", pc, 8'h03);

    // LD r1,[r2+5] with three memory wait cycles
    run_instr(16'h6285, 0, 3, 1'b0);
    chk("ld_cyc", r_cyc, 8);
    chk("ld_mem_cnt", r_mem, 4);
    chk("ld_memwe", r_memwe, 1'b0);
    chk("ld_imm", imm, 8'h05);
    chk("ld_we_cnt", r_we, 1);
    chk("ld_wdsel", r_wdsel, 1'b1);
    chk("ld_pc", pc, 8'h04);
    chk("ld_illegal", illegal, 1'b0);

    // ST r1,[r2+5]
    run_instr(16'h7285, 0, 0, 1'b0);
    chk("st_cyc", r_cyc, 4);
    chk("st_mem_cnt", r_mem, 1);
    chk("st_memwe", r_memwe, 1'b1);
    chk("st_we_cnt", r_we, 0);
    chk("st_ra", {ra1, ra2}, {3'd2, 3'd1});
    chk("st_pc", pc, 8'h05);

    run_instr(16'h3298, 0, 0, 1'b0);
    chk("and_ctl", r_ctl, 3'd2);
    run_instr(16'h4298, 0, 0, 1'b0);
    chk("or_ctl", r_ctl, 3'd3);
    chk("or_pc", pc, 8'h07);

    // BEQ taken from 0x10 with offset -2
    run_instr(16'h9010, 0, 0, 1'b0);
    chk("j10_cyc", r_cyc, 3);
    chk("j10_pc", pc, 8'h10);
    run_instr(16'h80BE, 0, 0, 1'b1);
    chk("beqt_cyc", r_cyc, 3);
    chk("beqt_ctl", r_ctl, 3'd1);
    chk("beqt_we_cnt", r_we, 0);
    chk("beqt_pc", pc, 8'h0F);

    // BEQ not taken
    run_instr(16'h9010, 0, 0, 1'b0);
    run_instr(16'h80BE, 0, 0, 1'b0);
    chk("beqn_pc", pc, 8'h11);

    // Jump to 0xFF, then NOP wraps
    run_instr(16'h90FF, 0, 0, 1'b0);
    chk("jff_pc", pc, 8'hFF);
    run_instr(16'h0000, 0, 0, 1'b0);
    chk("nop_cyc", r_cyc, 3);
    chk("wrap_pc", pc, 8'h00);

    // Illegal opcode is sticky and executes as NOP
    run_instr(16'hA000, 0, 0, 1'b0);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_side", {r_we[7:0], r_mem[7:0]}, 16'd0);
    chk("ill_pc", pc, 8'h01);
    run_instr(16'h0000, 0, 0, 1'b0);
    chk("ill_sticky", illegal, 1'b1);
    chk("ill_nop_pc", pc, 8'h02);

    // HALT
    run_instr(16'hF000, 0, 0, 1'b0);
    chk("halt_cyc", r_cyc, 3);
    chk("halt_flag", halted, 1'b1);
    chk("halt_pc", pc, 8'h02);
    hreq = 0;
    imem_valid = 1'b1;
    mem_ready  = 1'b1;
    instr      = 16'h1298;
    for (int i = 0; i < 20; i++) begin
      if (imem_req || we3 || mem_req || !halted) hreq++;
      tick();
    end
    imem_valid = 1'b0;
    mem_ready  = 1'b0;
    chk("halt_quiet", hreq, 0);
    chk("halt_pc_hold", pc, 8'h02);

    // Reset in the middle of a store's memory phase
    do_reset();
    run_instr(16'h9020, 0, 0, 1'b0);
    chk("j20_pc", pc, 8'h20);
    instr = 16'h7285;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    instr = 16'hA000;
    tick();
    tick();
    chk("mr_in_mem", {mem_req, mem_we}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_mem_req", mem_req, 1'b0);
    chk("mr_pc", pc, 8'h00);
    chk("mr_fetch", imem_req, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_idle", {imem_req, we3, mem_req, illegal}, 4'b1000);
    run_instr(16'h0000, 0, 0, 1'b0);
    chk("mr_resume_pc", pc, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
